// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Arbitrates two requesters onto one shared multi-cycle ALU and
//            returns the captured result to the granted requester.
// Options  : define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration
//            (default build is fixed priority, requester 0 wins).
// Revision : 1.0  initial release
// ============================================================================
module alu_share_arbiter #(
  parameter int BASE_CYCLES = 1,
  parameter int MUL_CYCLES  = 2,
  parameter int DIV_CYCLES  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_data1,
  input  logic [31:0] req0_data2,
  input  logic [5:0]  req0_select,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_data1,
  input  logic [31:0] req1_data2,
  input  logic [5:0]  req1_select,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic [31:0] alu_data1,
  output logic [31:0] alu_data2,
  output logic [5:0]  alu_select,
  input  logic [31:0] alu_result,
  output logic        busy
);

  localparam logic [3:0] c_base_cnt = 4'(BASE_CYCLES);
  localparam logic [3:0] c_mul_cnt  = 4'(MUL_CYCLES);
  localparam logic [3:0] c_div_cnt  = 4'(DIV_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_data1;
  logic [31:0] r_data2;
  logic [5:0]  r_select;
  logic        r_gnt_id;
  logic [3:0]  r_cnt;
  logic [31:0] r_result;

  logic        w_idle;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_accept;
  logic        w_accept_id;
  logic        w_rsp_hs;
  logic        w_capture;
  logic [31:0] w_sel_data1;
  logic [31:0] w_sel_data2;
  logic [5:0]  w_sel_select;

  function automatic logic [3:0] f_latency(input logic [5:0] sel);
    if (sel[5:2] == 4'b0011) begin
      return c_div_cnt;
    end else if (sel[5:2] == 4'b0010) begin
      return c_mul_cnt;
    end else begin
      return c_base_cnt;
    end
  endfunction

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // r_last_id = 1 means requester 1 was granted most recently
  logic r_last_id;

  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant0 = r_last_id;
      w_grant1 = ~r_last_id;
    end else begin
      w_grant0 = req0_valid;
      w_grant1 = req1_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_id <= 1'b1;
    end else if (w_accept) begin
      r_last_id <= w_accept_id;
    end
  end
`else
  assign w_grant0 = req0_valid;
  assign w_grant1 = req1_valid & ~req0_valid;
`endif

  // Reset gates READY directly so it drops without waiting for a clock
  assign w_idle      = (r_state == S_IDLE);
  assign req0_ready  = w_idle & w_grant0 & ~reset;
  assign req1_ready  = w_idle & w_grant1 & ~reset;
  assign w_accept    = req0_ready | req1_ready;
  assign w_accept_id = req1_ready;
  assign w_rsp_hs    = (r_state == S_RESP) & (r_gnt_id ? rsp1_ready : rsp0_ready);

  assign w_sel_data1  = w_accept_id ? req1_data1  : req0_data1;
  assign w_sel_data2  = w_accept_id ? req1_data2  : req0_data2;
  assign w_sel_select = w_accept_id ? req1_select : req0_select;

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_cnt == 4'd1) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp0_valid = ~r_gnt_id;
        rsp1_valid = r_gnt_id;
        if (w_rsp_hs) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_data1  <= 32'd0;
      r_data2  <= 32'd0;
      r_select <= 6'd0;
      r_gnt_id <= 1'b0;
      r_cnt    <= 4'd0;
      r_result <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_data1  <= w_sel_data1;
        r_data2  <= w_sel_data2;
        r_select <= w_sel_select;
        r_gnt_id <= w_accept_id;
        r_cnt    <= f_latency(w_sel_select);
      end else if (r_state == S_EXEC) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) begin
        r_result <= alu_result;
      end
    end
  end

  assign alu_data1  = r_data1;
  assign alu_data2  = r_data2;
  assign alu_select = r_select;
  assign rsp_result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Purpose  : Self-checking bench for alu_share_arbiter with a behavioural ALU,
//            a vector table and a response scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_data1, req0_data2, req1_data1, req1_data2;
  logic [5:0]  req0_select, req1_select;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp_result, alu_data1, alu_data2, alu_result;
  logic [5:0]  alu_select;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          id;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [5:0]  sel;
    int          lat;
    logic [31:0] exp;
    int          hold;
    bit          pulse;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] res;
  } sb_t;

  vec_t vecs[9];
  sb_t  sb_q[$];
  int   g_id[3];
  int   g_cyc[3];
  int   exp_order[3];

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_data1  (req0_data1),
    .req0_data2  (req0_data2),
    .req0_select (req0_select),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_data1  (req1_data1),
    .req1_data2  (req1_data2),
    .req1_select (req1_select),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp_result  (rsp_result),
    .alu_data1   (alu_data1),
    .alu_data2   (alu_data2),
    .alu_select  (alu_select),
    .alu_result  (alu_result),
    .busy        (busy)
  );

  // Behavioural shared ALU; unknown selects return data1 ^ data2
  logic [63:0] m_prod;
  always_comb begin
    m_prod = {32'd0, alu_data1} * {32'd0, alu_data2};
    case (alu_select)
      6'b000000: alu_result = alu_data1 + alu_data2;
      6'b000001: alu_result = alu_data1 - alu_data2;
      6'b001000: alu_result = m_prod[31:0];
      6'b001011: alu_result = m_prod[63:32];
      6'b001100: alu_result = (alu_data2 == 32'd0) ? 32'd0 : 32'($signed(alu_data1) / $signed(alu_data2));
      6'b001101: alu_result = (alu_data2 == 32'd0) ? 32'd0 : alu_data1 / alu_data2;
      6'b001110: alu_result = (alu_data2 == 32'd0) ? 32'd0 : 32'($signed(alu_data1) % $signed(alu_data2));
      6'b001111: alu_result = (alu_data2 == 32'd0) ? 32'd0 : alu_data1 % alu_data2;
      default:   alu_result = alu_data1 ^ alu_data2;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic rdy(input int id);
    return (id == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic rspv(input int id);
    return (id == 0) ? rsp0_valid : rsp1_valid;
  endfunction

  task automatic set_req(input int id, input logic v, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [5:0] sel);
    if (id == 0) begin
      req0_valid = v; req0_data1 = d1; req0_data2 = d2; req0_select = sel;
    end else begin
      req1_valid = v; req1_data1 = d1; req1_data2 = d2; req1_select = sel;
    end
  endtask

  task automatic set_rsp_ready(input int id, input logic v);
    if (id == 0) rsp0_ready = v;
    else         rsp1_ready = v;
  endtask

  task automatic sb_push(input int id, input logic [31:0] res);
    sb_t e;
    e.id  = id;
    e.res = res;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input int id);
    sb_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_rsp: got response on port %0d, expected none", id);
    end else begin
      e = sb_q.pop_front();
      chk("rsp_port", id, e.id);
      chk("rsp_result", rsp_result, e.res);
    end
  endtask

  task automatic chk_reset_outputs();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_req0_ready", req0_ready, 1'b0);
    chk1("rst_req1_ready", req1_ready, 1'b0);
    chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk1("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_alu_data1", alu_data1, 32'd0);
    chk("rst_alu_data2", alu_data2, 32'd0);
    chk("rst_alu_select", {26'd0, alu_select}, 32'd0);
  endtask

  // Every response handshake is checked against the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (rsp0_valid || rsp1_valid) chk1("one_rsp_valid", rsp0_valid & rsp1_valid, 1'b0);
      if (rsp0_valid && rsp0_ready) sb_pop(0);
      if (rsp1_valid && rsp1_ready) sb_pop(1);
    end
  end

  task automatic wait_drain();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("drain", sb_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #2;
    chk_reset_outputs();
    sb_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Entered and left 1 time unit after a rising edge
  task automatic do_op(input vec_t v);
    int k;
    set_req(v.id, 1'b1, v.d1, v.d2, v.sel);
    k = 0;
    @(negedge clk);
    while (!rdy(v.id) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk1("grant_seen", rdy(v.id), 1'b1);
    chk1("other_ready_low", rdy(1 - v.id), 1'b0);
    sb_push(v.id, v.exp);
    @(posedge clk); #1;
    set_req(v.id, 1'b0, v.d1, v.d2, v.sel);
    if (v.pulse) set_req(1 - v.id, 1'b1, 32'hDEADBEEF, 32'h1, 6'b000000);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      chk("alu_data1_stable", alu_data1, v.d1);
      chk("alu_data2_stable", alu_data2, v.d2);
      chk("alu_select_stable", {26'd0, alu_select}, {26'd0, v.sel});
      chk1("busy_in_op", busy, 1'b1);
      if (v.pulse && k == 1) begin
        chk1("busy_pulse_ready_low", rdy(1 - v.id), 1'b0);
        @(posedge clk); #1;
        set_req(1 - v.id, 1'b0, 32'hDEADBEEF, 32'h1, 6'b000000);
      end
    end while (!rspv(v.id) && k < 40);
    chk("latency", k, v.lat + 1);
    repeat (v.hold) begin
      @(negedge clk);
      chk1("rsp_valid_held", rspv(v.id), 1'b1);
      chk("rsp_result_held", rsp_result, v.exp);
    end
    @(posedge clk); #1;
    set_rsp_ready(v.id, 1'b1);
    @(negedge clk);
    @(posedge clk); #1;
    set_rsp_ready(v.id, 1'b0);
    @(negedge clk);
    chk1("idle_after_hs", busy, 1'b0);
    chk1("rsp_valid_after_hs", rspv(v.id), 1'b0);
    if (v.pulse) begin
      repeat (2) begin
        @(negedge clk);
        chk1("pulsed_not_accepted", busy, 1'b0);
        chk1("pulsed_no_rsp", rspv(1 - v.id), 1'b0);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cyc;
    vecs[0] = '{0, 32'd5,          32'd7,          6'b000000, 1, 32'd12,         0, 1'b0};
    vecs[1] = '{1, 32'hFFFFFFFF,   32'd2,          6'b001000, 2, 32'hFFFFFFFE,   1, 1'b1};
    vecs[2] = '{0, 32'd100,        32'd7,          6'b001100, 3, 32'd14,         2, 1'b0};
    vecs[3] = '{1, 32'd100,        32'd7,          6'b001110, 3, 32'd2,          0, 1'b0};
    vecs[4] = '{0, 32'hFFFFFFFF,   32'd2,          6'b001011, 2, 32'd1,          0, 1'b0};
    vecs[5] = '{1, 32'd100,        32'd7,          6'b001101, 3, 32'd14,         1, 1'b0};
    vecs[6] = '{0, 32'hF0F0F0F0,   32'h0FF00FF0,   6'b000111, 1, 32'hFF00FF00,   1, 1'b0};
    vecs[7] = '{1, 32'h12345678,   32'h0000FFFF,   6'b111111, 1, 32'h1234A987,   0, 1'b0};
    vecs[8] = '{0, 32'd100,        32'd7,          6'b001111, 3, 32'd2,          0, 1'b0};
`ifdef ALU_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0};
`else
    exp_order = '{0, 0, 0};
`endif

    // Power-on reset with a request already pending
    set_req(0, 1'b1, 32'd1, 32'd1, 6'b000000);
    set_req(1, 1'b0, 32'd0, 32'd0, 6'b000000);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    set_req(0, 1'b0, 32'd1, 32'd1, 6'b000000);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) do_op(vecs[i]);

    // Slow response consumer on port 0 while requester 1 waits
    set_req(0, 1'b1, 32'd5, 32'd7, 6'b000000);
    rsp1_ready = 1'b1;
    @(negedge clk);
    chk1("c_req0_ready", req0_ready, 1'b1);
    sb_push(0, 32'd12);
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'd5, 32'd7, 6'b000000);
    set_req(1, 1'b1, 32'd100, 32'd7, 6'b001110);
    @(negedge clk);
    chk1("c_req1_blocked_exec", req1_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("c_rsp0_held", rsp0_valid, 1'b1);
      chk("c_result_held", rsp_result, 32'd12);
      chk1("c_req1_blocked_resp", req1_ready, 1'b0);
      chk1("c_rsp1_low", rsp1_valid, 1'b0);
    end
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk1("c_req1_blocked_hs", req1_ready, 1'b0);
    @(negedge clk);
    chk1("c_req1_granted", req1_ready, 1'b1);
    sb_push(1, 32'd2);
    @(posedge clk); #1;
    set_req(1, 1'b0, 32'd100, 32'd7, 6'b001110);
    rsp0_ready = 1'b0;
    wait_drain();
    rsp1_ready = 1'b0;

    // Reset in the middle of a divide
    set_req(0, 1'b1, 32'd100, 32'd7, 6'b001100);
    @(negedge clk);
    chk1("d_req0_ready", req0_ready, 1'b1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'd100, 32'd7, 6'b001100);
    #3;
    set_req(1, 1'b1, 32'd3, 32'd4, 6'b000000);
    reset = 1'b1;
    #1;
    chk_reset_outputs();
    set_req(1, 1'b0, 32'd3, 32'd4, 6'b000000);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk1("d_no_busy", busy, 1'b0);
      chk1("d_no_rsp0", rsp0_valid, 1'b0);
    end
    @(posedge clk); #1;
    do_op(vecs[0]);

    // Both requesters valid continuously
    apply_reset();
    set_req(0, 1'b1, 32'd100, 32'd7, 6'b001100);
    set_req(1, 1'b1, 32'd100, 32'd7, 6'b001110);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 3 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (req0_ready || req1_ready) begin
        chk1("b_single_ready", req0_ready & req1_ready, 1'b0);
        g_id[n]  = req1_ready ? 1 : 0;
        g_cyc[n] = cyc;
        sb_push(g_id[n], (g_id[n] == 1) ? 32'd2 : 32'd14);
        n++;
      end
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'd100, 32'd7, 6'b001100);
    set_req(1, 1'b0, 32'd100, 32'd7, 6'b001110);
    chk("b_grant_count", n, 32'd3);
    if (n == 3) begin
      for (int i = 0; i < 3; i++) chk("b_grant_order", g_id[i], exp_order[i]);
      for (int i = 1; i < 3; i++) chk("b_grant_gap", g_cyc[i] - g_cyc[i-1], 32'd5);
    end
    wait_drain();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
